iis_master_ctrl: RTL and testbench

IIS bus master between the FIR datapath and the audio codec (or the codec dummy device in simulation). It generates AC_MCLK, AC_BCLK and AC_LRCLK from clk_i. It serialises 24-bit left/right FIR output samples onto AC_DAC_SDATA and deserialises 16-bit left/right ADC samples from AC_ADC_SDATA. Format is standard I2S: MSB first, one BCLK delay after each LRCLK edge, LRCLK low = left channel.

---
 rtl/iis_master_ctrl.sv | 115 +++++++++++
 tb/tb_iis_master_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iis_master_ctrl.sv
// iis_master_ctrl: I2S bus master generating MCLK/BCLK/LRCLK, serialising DAC pairs and
// deserialising ADC pairs (MSB first, one BCLK after each LRCLK edge, LRCLK low = left).
module iis_master_ctrl #(
  parameter int DATA_SIZE         = 16,
  parameter int DATA_SIZE_FIR_OUT = 24,
  parameter int MCLK_HALF         = 2,
  parameter int BCLK_HALF         = 8,
  parameter int BITS_PER_CH       = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [DATA_SIZE_FIR_OUT-1:0] tx_data_l_i,
  input  logic [DATA_SIZE_FIR_OUT-1:0] tx_data_r_i,
  input  logic                         tx_valid_i,
  output logic                         tx_ready_o,
  output logic                         tx_underrun_o,
  output logic [DATA_SIZE-1:0]         rx_data_l_o,
  output logic [DATA_SIZE-1:0]         rx_data_r_o,
  output logic                         rx_valid_o,
  output logic                         AC_MCLK,
  output logic                         AC_BCLK,
  output logic                         AC_LRCLK,
  output logic                         AC_DAC_SDATA,
  input  logic                         AC_ADC_SDATA
);
  localparam int MW = $clog2(MCLK_HALF + 1);
  localparam int BW = $clog2(BCLK_HALF + 1);
  localparam int CW = $clog2(BITS_PER_CH);
  localparam int TW = DATA_SIZE_FIR_OUT;
  logic [MW-1:0] mcnt;
  logic [BW-1:0] bcnt;
  logic [CW-1:0] bit_cnt, cnt_nxt;
  logic [TW-1:0] hold_l, hold_r, word_l, word_r, tx_sh;
  logic [DATA_SIZE-2:0] rx_sh;
  logic [DATA_SIZE-1:0] rx_left, rx_word;
  logic mwrap, bwrap, rise_evt, fall_evt, slot_end, frame_start, capture, tx_bit, rx_bit, rx_last;
  always_comb begin
    mwrap       = mcnt == MW'(MCLK_HALF - 1);
    bwrap       = bcnt == BW'(BCLK_HALF - 1);
    rise_evt    = bwrap && !AC_BCLK;
    fall_evt    = bwrap && AC_BCLK;
    slot_end    = bit_cnt == CW'(BITS_PER_CH - 1);
    cnt_nxt     = slot_end ? '0 : bit_cnt + 1'b1;
    frame_start = fall_evt && slot_end && AC_LRCLK;
    capture     = tx_valid_i && tx_ready_o;
    tx_bit      = cnt_nxt >= CW'(1) && cnt_nxt <= CW'(TW);
    rx_bit      = bit_cnt >= CW'(1) && bit_cnt <= CW'(DATA_SIZE);
    rx_last     = rise_evt && bit_cnt == CW'(DATA_SIZE);
    rx_word     = {rx_sh, AC_ADC_SDATA};
  end
  // bit_cnt starts at the last slot position so the first BCLK fall opens the left slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcnt     <= '0;
      AC_MCLK  <= 1'b0;
      bcnt     <= '0;
      AC_BCLK  <= 1'b0;
      bit_cnt  <= CW'(BITS_PER_CH - 1);
      AC_LRCLK <= 1'b1;
    end else begin
      mcnt <= mwrap ? '0 : mcnt + 1'b1;
      bcnt <= bwrap ? '0 : bcnt + 1'b1;
      if (mwrap) AC_MCLK <= ~AC_MCLK;
      if (bwrap) AC_BCLK <= ~AC_BCLK;
      if (fall_evt) bit_cnt <= cnt_nxt;
      if (fall_evt && slot_end) AC_LRCLK <= ~AC_LRCLK;
    end
  end
  // word_l/word_r hold the pair on air so an empty holding register replays it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_l        <= '0;
      hold_r        <= '0;
      word_l        <= '0;
      word_r        <= '0;
      tx_sh         <= '0;
      tx_ready_o    <= 1'b1;
      tx_underrun_o <= 1'b0;
      AC_DAC_SDATA  <= 1'b0;
    end else begin
      tx_underrun_o <= frame_start && tx_ready_o;
      if (capture) begin
        hold_l     <= tx_data_l_i;
        hold_r     <= tx_data_r_i;
        tx_ready_o <= 1'b0;
      end else if (frame_start) tx_ready_o <= 1'b1;
      if (frame_start && !tx_ready_o) begin
        word_l <= hold_l;
        word_r <= hold_r;
      end
      if (fall_evt) begin
        if (slot_end) tx_sh <= AC_LRCLK ? (tx_ready_o ? word_l : hold_l) : word_r;
        else if (tx_bit) tx_sh <= tx_sh << 1;
        AC_DAC_SDATA <= tx_bit && tx_sh[TW-1];
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sh       <= '0;
      rx_left     <= '0;
      rx_data_l_o <= '0;
      rx_data_r_o <= '0;
      rx_valid_o  <= 1'b0;
    end else begin
      rx_valid_o <= rx_last && AC_LRCLK;
      if (rise_evt && rx_bit) rx_sh <= rx_word[DATA_SIZE-2:0];
      if (rx_last && !AC_LRCLK) rx_left <= rx_word;
      if (rx_last && AC_LRCLK) begin
        rx_data_l_o <= rx_left;
        rx_data_r_o <= rx_word;
      end
    end
  end
endmodule

// File: tb/tb_iis_master_ctrl.sv
// tb_iis_master_ctrl: bench with a pin-level I2S codec model, frame-level tx/rx
// scoreboard, a directed frame table, random frames and hand-written corner sequences.
module tb_iis_master_ctrl;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [23:0] tx_data_l_i = '0, tx_data_r_i = '0;
  logic tx_valid_i = 1'b0, tx_ready_o, tx_underrun_o, rx_valid_o;
  logic [15:0] rx_data_l_o, rx_data_r_o;
  logic AC_MCLK, AC_BCLK, AC_LRCLK, AC_DAC_SDATA;
  logic AC_ADC_SDATA = 1'b0;

  iis_master_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .tx_data_l_i(tx_data_l_i), .tx_data_r_i(tx_data_r_i), .tx_valid_i(tx_valid_i),
    .tx_ready_o(tx_ready_o), .tx_underrun_o(tx_underrun_o),
    .rx_data_l_o(rx_data_l_o), .rx_data_r_o(rx_data_r_o), .rx_valid_o(rx_valid_o),
    .AC_MCLK(AC_MCLK), .AC_BCLK(AC_BCLK), .AC_LRCLK(AC_LRCLK),
    .AC_DAC_SDATA(AC_DAC_SDATA), .AC_ADC_SDATA(AC_ADC_SDATA)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        send;
    logic [23:0] tl, tr;
    logic [15:0] al, ar;
    logic        eu;
    logic [23:0] edl, edr;
  } vec_t;

  int n_vec = 0, n_err = 0, cyc = 0;
  int rx_cnt = 0, rx_seen = 0, fs_cyc = 0, fs_prev = 0, dac_nz = 0, lr_viol = 0;
  logic [15:0] rx_l, rx_r, adc_l = '0, adc_r = '0, adc_sh;
  logic [23:0] cap_sh, cap_l = '0, cap_r = '0;
  int ck = 100;
  logic cod_lr = 1'b1, mon_lr = 1'b1, mon_b = 1'b0, mon_rst = 1'b0;
  vec_t vt[6];
  vec_t pend;
  logic pend_ok = 1'b0;
  logic sent_prev;
  logic [47:0] last_tx, sent_pair;

  always @(posedge clk_i) cyc++;

  // codec model: counts BCLK falls since the last LRCLK edge; drives ADC after falls, samples DAC on rises
  always @(negedge rst_ni) begin
    cod_lr = 1'b1;
    ck = 100;
  end
  always @(negedge AC_BCLK) begin
    ck = (AC_LRCLK != cod_lr) ? 0 : ck + 1;
    cod_lr = AC_LRCLK;
    if (ck == 1) adc_sh = cod_lr ? adc_r : adc_l;
    if (ck >= 1 && ck <= 16) begin
      AC_ADC_SDATA = adc_sh[15];
      adc_sh = adc_sh << 1;
    end else AC_ADC_SDATA = 1'b0;
  end
  always @(posedge AC_BCLK) begin
    if (ck >= 1 && ck <= 24) cap_sh = {cap_sh[22:0], AC_DAC_SDATA};
    if (ck == 24 && cod_lr) cap_r = cap_sh;
    if (ck == 24 && !cod_lr) cap_l = cap_sh;
    if (rst_ni && (ck == 0 || (ck > 24 && ck < 32)) && AC_DAC_SDATA !== 1'b0) dac_nz++;
  end

  always @(negedge clk_i) begin
    if (rx_valid_o) begin
      rx_cnt++;
      rx_l = rx_data_l_o;
      rx_r = rx_data_r_o;
    end
    if (rst_ni && mon_rst && AC_LRCLK !== mon_lr && !(mon_b && !AC_BCLK)) lr_viol++;
    mon_lr = AC_LRCLK;
    mon_b = AC_BCLK;
    mon_rst = rst_ni;
  end

  initial begin
    repeat (60000) @(posedge clk_i);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // returns at the falling clk edge of the first cycle with LRCLK low
  task automatic wait_fall();
    @(negedge AC_LRCLK);
    @(negedge clk_i);
    fs_prev = fs_cyc;
    fs_cyc = cyc;
  endtask

  task automatic frame_step(input vec_t v);
    wait_fall();
    chk("underrun", tx_underrun_o, v.eu);
    if (pend_ok) begin
      chk("lrclk_period", fs_cyc - fs_prev, 1024);
      chk("dac_l", cap_l, pend.edl);
      chk("dac_r", cap_r, pend.edr);
      chk("rx_pulses", rx_cnt - rx_seen, 1);
      chk("rx_l", rx_l, pend.al);
      chk("rx_r", rx_r, pend.ar);
    end
    pend = v;
    pend_ok = 1'b1;
    rx_seen = rx_cnt;
    adc_l = v.al;
    adc_r = v.ar;
    if (v.send) begin
      chk("ready_at_start", tx_ready_o, 1);
      tx_data_l_i = v.tl;
      tx_data_r_i = v.tr;
      tx_valid_i = 1'b1;
      @(negedge clk_i);
      tx_valid_i = 1'b0;
      chk("ready_drop", tx_ready_o, 0);
    end
  endtask

  initial begin
    int t0;
    vec_t f;
    vt[0] = '{1'b1, 24'hA5A5A5, 24'h5A5A5A, 16'h1234, 16'hBEEF, 1'b1, 24'h000000, 24'h000000};
    vt[1] = '{1'b0, 24'h000000, 24'h000000, 16'h1234, 16'hBEEF, 1'b0, 24'hA5A5A5, 24'h5A5A5A};
    vt[2] = '{1'b1, 24'h123456, 24'hABCDEF, 16'h0001, 16'h8000, 1'b1, 24'hA5A5A5, 24'h5A5A5A};
    vt[3] = '{1'b1, 24'hFFFFFF, 24'h000000, 16'hFFFF, 16'h0000, 1'b0, 24'h123456, 24'hABCDEF};
    vt[4] = '{1'b0, 24'h000000, 24'h000000, 16'h8001, 16'h7FFE, 1'b0, 24'hFFFFFF, 24'h000000};
    vt[5] = '{1'b0, 24'h000000, 24'h000000, 16'h0000, 16'hFFFF, 1'b1, 24'hFFFFFF, 24'h000000};
    repeat (3) @(negedge clk_i);
    chk("rst_mclk", AC_MCLK, 0);
    chk("rst_bclk", AC_BCLK, 0);
    chk("rst_lrclk", AC_LRCLK, 1);
    chk("rst_dac", AC_DAC_SDATA, 0);
    chk("rst_ready", tx_ready_o, 1);
    chk("rst_underrun", tx_underrun_o, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_rx_l", rx_data_l_o, 0);
    chk("rst_rx_r", rx_data_r_o, 0);
    rst_ni = 1'b1;
    @(posedge AC_MCLK);
    t0 = cyc;
    @(posedge AC_MCLK);
    chk("mclk_period", cyc - t0, 4);
    chk("lr_high_before_bclk_fall", AC_LRCLK, 1);
    @(negedge AC_BCLK);
    #1 chk("first_lr_fall", AC_LRCLK, 0);
    t0 = cyc;
    @(negedge AC_BCLK);
    chk("bclk_period", cyc - t0, 16);
    for (int i = 0; i < 6; i++) frame_step(vt[i]);
    sent_prev = vt[5].send;
    sent_pair = {vt[5].tl, vt[5].tr};
    last_tx = {vt[5].edl, vt[5].edr};
    for (int i = 0; i < 12; i++) begin
      vec_t v;
      v.eu = !sent_prev;
      {v.edl, v.edr} = sent_prev ? sent_pair : last_tx;
      last_tx = {v.edl, v.edr};
      v.send = $urandom_range(0, 2) != 0;
      v.tl = 24'($urandom);
      v.tr = 24'($urandom);
      v.al = 16'($urandom);
      v.ar = 16'($urandom);
      sent_prev = v.send;
      sent_pair = {v.tl, v.tr};
      frame_step(v);
    end
    f = '{default: '0};
    f.eu = !sent_prev;
    {f.edl, f.edr} = sent_prev ? sent_pair : last_tx;
    frame_step(f);
    pend_ok = 1'b0;
    // back-to-back pairs: the second waits in the handshake until the next frame start
    tx_data_l_i = 24'h111111;
    tx_data_r_i = 24'h222222;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    chk("b2b_first_taken", tx_ready_o, 0);
    tx_data_l_i = 24'h333333;
    tx_data_r_i = 24'h444444;
    repeat (50) @(negedge clk_i);
    chk("b2b_stall", tx_ready_o, 0);
    wait_fall();
    chk("b2b_underrun", tx_underrun_o, 0);
    chk("b2b_ready_at_start", tx_ready_o, 1);
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    chk("b2b_second_taken", tx_ready_o, 0);
    wait_fall();
    chk("b2b_underrun2", tx_underrun_o, 0);
    chk("b2b_dac_l1", cap_l, 24'h111111);
    chk("b2b_dac_r1", cap_r, 24'h222222);
    wait_fall();
    chk("b2b_underrun3", tx_underrun_o, 1);
    chk("b2b_dac_l2", cap_l, 24'h333333);
    chk("b2b_dac_r2", cap_r, 24'h444444);
    // valid raised exactly in the last LRCLK-high cycle, i.e. the frame-start cycle
    repeat (1023) @(negedge clk_i);
    chk("sim_lr_high", AC_LRCLK, 1);
    chk("sim_ready", tx_ready_o, 1);
    tx_data_l_i = 24'hA5A5A5;
    tx_data_r_i = 24'h5A5A5A;
    tx_valid_i = 1'b1;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
    chk("sim_lr_fell", AC_LRCLK, 0);
    chk("sim_underrun", tx_underrun_o, 1);
    chk("sim_captured", tx_ready_o, 0);
    wait_fall();
    chk("sim_underrun2", tx_underrun_o, 0);
    chk("sim_replay_l", cap_l, 24'h333333);
    chk("sim_replay_r", cap_r, 24'h444444);
    wait_fall();
    chk("sim_underrun3", tx_underrun_o, 1);
    chk("sim_dac_l", cap_l, 24'hA5A5A5);
    chk("sim_dac_r", cap_r, 24'h5A5A5A);
    // reset around bit 10 of the left slot
    adc_l = 16'h1234;
    adc_r = 16'hBEEF;
    repeat (168) @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_mclk", AC_MCLK, 0);
    chk("mid_rst_bclk", AC_BCLK, 0);
    chk("mid_rst_lrclk", AC_LRCLK, 1);
    chk("mid_rst_dac", AC_DAC_SDATA, 0);
    chk("mid_rst_ready", tx_ready_o, 1);
    chk("mid_rst_underrun", tx_underrun_o, 0);
    chk("mid_rst_rx_valid", rx_valid_o, 0);
    chk("mid_rst_rx_l", rx_data_l_o, 0);
    chk("mid_rst_rx_r", rx_data_r_o, 0);
    rx_seen = rx_cnt;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    wait_fall();
    chk("post_rst_underrun", tx_underrun_o, 1);
    chk("post_rst_no_rx", rx_cnt - rx_seen, 0);
    wait_fall();
    chk("post_rst_rx_pulses", rx_cnt - rx_seen, 1);
    chk("post_rst_rx_l", rx_l, 16'h1234);
    chk("post_rst_rx_r", rx_r, 16'hBEEF);
    chk("post_rst_dac_l", cap_l, 0);
    chk("post_rst_dac_r", cap_r, 0);
    chk("lrclk_on_bclk_fall", lr_viol, 0);
    chk("dac_idle_zero", dac_nz, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
